// File: rtl/sudoku_ctrl_pkg.sv
// rtl/sudoku_ctrl_pkg.sv - board constants, controller states and reject codes for digit entry
package sudoku_ctrl_pkg;

    localparam int BOARD_DIM = 9;
    localparam int CELLS     = 81;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PREDICT,
        WAIT,
        COMMIT,
        REJECT,
        CLEAR
    } ctrl_state_t;

    localparam logic [1:0] REJ_DIGIT   = 2'd0;
    localparam logic [1:0] REJ_RANGE   = 2'd1;
    localparam logic [1:0] REJ_FIXED   = 2'd2;
    localparam logic [1:0] REJ_TIMEOUT = 2'd3;

    function automatic logic coord_in_range(input logic [3:0] col, input logic [3:0] row);
        return (col < 4'(BOARD_DIM)) && (row < 4'(BOARD_DIM));
    endfunction

    // Only meaningful for in-range coordinates; callers gate on coord_in_range first.
    function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return 7'(row) * 7'(BOARD_DIM) + 7'(col);
    endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// rtl/ctrl_timeout_counter.sv - predictor wait counter with clear, enable and expiry at TIMEOUT_CYCLES-1
module ctrl_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a stalled enable never wraps back into a fresh window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/predict_commit_ctrl.sv
// rtl/predict_commit_ctrl.sv - stroke-to-solver digit entry sequencer; optional PENDING_SLOT_EN stroke buffer
module predict_commit_ctrl
    import sudoku_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             game_active,
    input  logic             draw_valid,
    input  logic [3:0]       block_x,
    input  logic [3:0]       block_y,
    input  logic [CELLS-1:0] cell_blank,
    output logic             pred_start,
    input  logic             pred_finish,
    input  logic [3:0]       pred_number,
    output logic             wr_en,
    output logic [3:0]       wr_row,
    output logic [3:0]       wr_col,
    output logic [3:0]       wr_data,
    output logic             track_clear,
    output logic             reject,
    output logic [1:0]       reject_code,
    output logic             busy
);

    ctrl_state_t state;
    logic [3:0]  lat_x;
    logic [3:0]  lat_y;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;
    logic        target_in_range;
    logic        target_blank;
    logic        digit_ok;

`ifdef PENDING_SLOT_EN
    logic       slot_full;
    logic [3:0] slot_x;
    logic [3:0] slot_y;
`endif

    assign tmo_clear  = (state == PREDICT);
    assign tmo_enable = (state == WAIT);
    assign digit_ok   = (pred_number != 4'd0) && (pred_number <= 4'd9);
    assign wr_row     = lat_y;
    assign wr_col     = lat_x;

    always_comb begin
        target_in_range = coord_in_range(lat_x, lat_y);
        target_blank    = 1'b0;
        if (target_in_range) begin
            target_blank = cell_blank[cell_index(lat_y, lat_x)];
        end
    end

    ctrl_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_x       <= '0;
            lat_y       <= '0;
            wr_data     <= '0;
            reject_code <= REJ_DIGIT;
            pred_start  <= 1'b0;
            wr_en       <= 1'b0;
            reject      <= 1'b0;
            track_clear <= 1'b0;
            busy        <= 1'b0;
`ifdef PENDING_SLOT_EN
            slot_full   <= 1'b0;
            slot_x      <= '0;
            slot_y      <= '0;
`endif
        end else begin
            pred_start  <= 1'b0;
            wr_en       <= 1'b0;
            reject      <= 1'b0;
            track_clear <= 1'b0;
`ifdef PENDING_SLOT_EN
            if (state != IDLE && draw_valid && game_active) begin
                slot_full <= 1'b1;
                slot_x    <= block_x;
                slot_y    <= block_y;
            end
`endif
            // Leaving the game aborts any attempt in flight; CLEAR is already the exit path.
            if (state != IDLE && state != CLEAR && !game_active) begin
                state       <= CLEAR;
                track_clear <= 1'b1;
`ifdef PENDING_SLOT_EN
                slot_full   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (draw_valid && game_active) begin
                            lat_x <= block_x;
                            lat_y <= block_y;
                            state <= CHECK;
                            busy  <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (!target_in_range) begin
                            state       <= REJECT;
                            reject      <= 1'b1;
                            reject_code <= REJ_RANGE;
                        end else if (!target_blank) begin
                            state       <= REJECT;
                            reject      <= 1'b1;
                            reject_code <= REJ_FIXED;
                        end else begin
                            state      <= PREDICT;
                            pred_start <= 1'b1;
                        end
                    end
                    PREDICT: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (pred_finish) begin
                            if (digit_ok) begin
                                wr_data <= pred_number;
                                state   <= COMMIT;
                                wr_en   <= 1'b1;
                            end else begin
                                state       <= REJECT;
                                reject      <= 1'b1;
                                reject_code <= REJ_DIGIT;
                            end
                        end else if (tmo_expired) begin
                            state       <= REJECT;
                            reject      <= 1'b1;
                            reject_code <= REJ_TIMEOUT;
                        end
                    end
                    COMMIT, REJECT: begin
                        state       <= CLEAR;
                        track_clear <= 1'b1;
                    end
                    CLEAR: begin
`ifdef PENDING_SLOT_EN
                        // A stroke arriving in this very cycle is newer than the slot.
                        if (game_active && (draw_valid || slot_full)) begin
                            lat_x <= draw_valid ? block_x : slot_x;
                            lat_y <= draw_valid ? block_y : slot_y;
                            state <= CHECK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        slot_full <= 1'b0;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
